sp_sram_arbiter: RTL

Two-port request/grant arbiter that shares one single-port 8192x8 SRAM, with 1-cycle read latency, between two requesters. Port 0 is the shortest-path engine. Port 1 is the host loader/readback path, which fills M before a run and reads L/P afterwards. One instance sits in front of each of the M, L and P SRAMs. A lock input lets the engine own the SRAM outright for its fixed-timing accesses, so the engine never stalls.

---
 rtl/sp_pkg.sv | 10 +
 rtl/sp_rd_return.sv | 39 +++
 rtl/sp_sram_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/sp_pkg.sv
// sp_pkg: shared widths, P-memory direction codes and arbiter priority-state encoding
package sp_pkg;
  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = 13;
  localparam int MAX_WORDS = 8192;
  localparam logic [7:0] START = 8'h08;
  localparam logic [7:0] RIGHT = 8'h09;
  localparam logic [7:0] DOWN = 8'h0A;
  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_e;
endpackage

// File: rtl/sp_rd_return.sv
// sp_rd_return: 2-stage read tag pipeline (acc/owner in) steering S_Rdata to R0/R1 Rdata+Rvalid, busy = any tag valid
module sp_rd_return #(
  parameter int D_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               acc,
  input  logic               owner,
  input  logic [D_WIDTH-1:0] S_Rdata,
  output logic [D_WIDTH-1:0] R0_Rdata,
  output logic               R0_Rvalid,
  output logic [D_WIDTH-1:0] R1_Rdata,
  output logic               R1_Rvalid,
  output logic               busy
);
  import sp_pkg::*;
  logic [1:0] v, o;
  logic [D_WIDTH-1:0] hold0, hold1;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      v <= '0;
      o <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      v <= {v[0], acc};
      o <= {o[0], owner};
      if (R0_Rvalid) hold0 <= S_Rdata;
      if (R1_Rvalid) hold1 <= S_Rdata;
    end
  end
  always_comb begin
    R0_Rvalid = v[1] & ~o[1];
    R1_Rvalid = v[1] & o[1];
    R0_Rdata = R0_Rvalid ? S_Rdata : hold0;
    R1_Rdata = R1_Rvalid ? S_Rdata : hold1;
    busy = |v;
  end
endmodule

// File: rtl/sp_sram_arbiter.sv
// sp_sram_arbiter: two-port req/gnt arbiter (Lock0 gives port 0 exclusive use) driving one single-port SRAM S_* with read return to R0/R1 and Busy
module sp_sram_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 13
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Lock0,
  input  logic               R0_Req,
  input  logic               R0_Rw,
  input  logic [A_WIDTH-1:0] R0_Addr,
  input  logic [D_WIDTH-1:0] R0_Wdata,
  output logic               R0_Gnt,
  output logic [D_WIDTH-1:0] R0_Rdata,
  output logic               R0_Rvalid,
  input  logic               R1_Req,
  input  logic               R1_Rw,
  input  logic [A_WIDTH-1:0] R1_Addr,
  input  logic [D_WIDTH-1:0] R1_Wdata,
  output logic               R1_Gnt,
  output logic [D_WIDTH-1:0] R1_Rdata,
  output logic               R1_Rvalid,
  output logic               S_En,
  output logic               S_Rw,
  output logic [A_WIDTH-1:0] S_Addr,
  output logic [D_WIDTH-1:0] S_Wdata,
  input  logic [D_WIDTH-1:0] S_Rdata,
  output logic               Busy
);
  import sp_pkg::*;
  pri_e state, state_next;
  logic rd_acc, pipe_busy;
  always_ff @(posedge Clk) begin
    if (Rst) state <= PRI0;
    else state <= state_next;
  end
  always_comb begin
    R0_Gnt = ~Rst & R0_Req & (Lock0 | ~R1_Req | state == PRI0);
    R1_Gnt = ~Rst & R1_Req & ~Lock0 & (~R0_Req | state == PRI1);
    state_next = R1_Gnt ? PRI0 : (R0_Gnt & ~Lock0) ? PRI1 : state;
    rd_acc = (R0_Gnt & ~R0_Rw) | (R1_Gnt & ~R1_Rw);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      S_En <= 1'b0;
      S_Rw <= 1'b0;
      S_Addr <= '0;
      S_Wdata <= '0;
    end else begin
      S_En <= R0_Gnt | R1_Gnt;
      S_Rw <= R0_Gnt ? R0_Rw : R1_Gnt & R1_Rw;
      S_Addr <= R0_Gnt ? R0_Addr : R1_Gnt ? R1_Addr : '0;
      S_Wdata <= R0_Gnt ? R0_Wdata : R1_Gnt ? R1_Wdata : '0;
    end
  end
  sp_rd_return #(.D_WIDTH(D_WIDTH)) u_ret (
    .Clk(Clk),
    .Rst(Rst),
    .acc(rd_acc),
    .owner(R1_Gnt),
    .S_Rdata(S_Rdata),
    .R0_Rdata(R0_Rdata),
    .R0_Rvalid(R0_Rvalid),
    .R1_Rdata(R1_Rdata),
    .R1_Rvalid(R1_Rvalid),
    .busy(pipe_busy)
  );
  assign Busy = S_En | pipe_busy;
endmodule
